reshaper_mem_responder: RTL and testbench

//  Memory-side responder for the reshaper's read/write request interface. Accepts one

---
 rtl/reshaper_mem_responder.sv | 106 ++++++++++
 tb/tb_reshaper_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reshaper_mem_responder.sv
// Memory-side responder for the reshaper request interface: fixed-latency read pipeline,
// single write port with a lower-priority preload port, and error/occupancy status.
module reshaper_mem_responder #(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 512,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned MEM_DELAY = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [AW-1:0]                        raddr,
   input  logic                                 raddr_vld,
   output logic [DW-1:0]                        rdata,
   output logic                                 rdata_vld,
   input  logic [AW-1:0]                        waddr,
   input  logic [DW-1:0]                        wdata,
   input  logic                                 wdata_vld,
   input  logic [AW-1:0]                        ld_addr,
   input  logic [DW-1:0]                        ld_data,
   input  logic                                 ld_vld,
   output logic [AW-1:0]                        rd_cnt,
   output logic [AW-1:0]                        wr_cnt,
   output logic [$clog2(MEM_DELAY+1)-1:0]       inflight,
   output logic                                 rd_err,
   output logic                                 wr_err,
   input  logic                                 err_clr
);

   localparam int unsigned IW = $clog2(MEM_DELAY + 1);
   localparam int unsigned XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          rd_in_range;
   logic          wr_in_range;
   logic          ld_in_range;
   logic          wr_do;
   logic          ld_do;
   logic          rd_err_set;
   logic          wr_err_set;
   logic [DW-1:0] rd_word;

   logic [DW-1:0]        mem [DEPTH];
   logic [MEM_DELAY-1:0] pipe_vld;
   logic [DW-1:0]        pipe_data [MEM_DELAY];

   // Range checks are done one bit wider so DEPTH == 2**AW is handled correctly.
   always_comb begin
      rd_in_range = ({1'b0, raddr}   < (AW+1)'(DEPTH));
      wr_in_range = ({1'b0, waddr}   < (AW+1)'(DEPTH));
      ld_in_range = ({1'b0, ld_addr} < (AW+1)'(DEPTH));
      wr_do       = wdata_vld && wr_in_range;
      ld_do       = ld_vld && !wdata_vld && ld_in_range;
      rd_err_set  = raddr_vld && !rd_in_range;
      wr_err_set  = (wdata_vld && !wr_in_range) || (ld_vld && !wdata_vld && !ld_in_range);
      rd_word     = '0;
      if (rd_in_range) rd_word = mem[raddr[XW-1:0]];
   end

   // Array is never reset; the write port takes priority over preload.
   always_ff @(posedge clk) begin
      if (wr_do) begin
         mem[waddr[XW-1:0]] <= wdata;
      end else if (ld_do) begin
         mem[ld_addr[XW-1:0]] <= ld_data;
      end
   end

   // Data stages only advance behind a valid bit, so the last stage holds between responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld <= '0;
         for (int k = 0; k < int'(MEM_DELAY); k++) pipe_data[k] <= '0;
      end else begin
         pipe_vld[0] <= raddr_vld;
         if (raddr_vld) pipe_data[0] <= rd_word;
         for (int k = 1; k < int'(MEM_DELAY); k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            if (pipe_vld[k-1]) pipe_data[k] <= pipe_data[k-1];
         end
      end
   end

   assign rdata_vld = pipe_vld[MEM_DELAY-1];
   assign rdata     = pipe_data[MEM_DELAY-1];

   // Status counters and sticky error flags; a new error wins over a same-edge clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         inflight <= '0;
         rd_err   <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         if (raddr_vld) rd_cnt <= rd_cnt + AW'(1);
         if (wdata_vld) wr_cnt <= wr_cnt + AW'(1);
         case ({raddr_vld, rdata_vld})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: inflight <= inflight;
         endcase
         rd_err <= rd_err_set | (rd_err & ~err_clr);
         wr_err <= wr_err_set | (wr_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_reshaper_mem_responder.sv
// Directed bench for reshaper_mem_responder: a reference memory feeds a response
// scoreboard that checks data, order and exact latency of every rdata_vld.
module tb_reshaper_mem_responder;

   localparam int unsigned AW        = 16;
   localparam int unsigned DW        = 512;
   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned MEM_DELAY = 8;
   localparam int unsigned IW        = $clog2(MEM_DELAY + 1);

   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } resp_t;

   logic          clk;
   logic          reset;
   logic [AW-1:0] raddr;
   logic          raddr_vld;
   logic [DW-1:0] rdata;
   logic          rdata_vld;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          wdata_vld;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_vld;
   logic [AW-1:0] rd_cnt;
   logic [AW-1:0] wr_cnt;
   logic [IW-1:0] inflight;
   logic          rd_err;
   logic          wr_err;
   logic          err_clr;

   logic [DW-1:0] model [DEPTH];
   resp_t         sb [$];
   int            edge_cnt = 0;
   int            n_chk    = 0;
   int            n_fail   = 0;
   logic [AW-1:0] exp_rd_cnt = '0;
   logic [AW-1:0] exp_wr_cnt = '0;
   logic [DW-1:0] pat_a5;
   logic [DW-1:0] pat_p;

   reshaper_mem_responder #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .MEM_DELAY(MEM_DELAY)
   ) dut (
      .clk(clk), .reset(reset),
      .raddr(raddr), .raddr_vld(raddr_vld),
      .rdata(rdata), .rdata_vld(rdata_vld),
      .waddr(waddr), .wdata(wdata), .wdata_vld(wdata_vld),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_vld(ld_vld),
      .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .inflight(inflight),
      .rd_err(rd_err), .wr_err(wr_err), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: update the reference model as the DUT samples, queue expected responses.
   task automatic tick();
      logic          do_rd;
      logic [DW-1:0] e;
      @(posedge clk);
      do_rd = !reset && raddr_vld;
      e = (raddr < DEPTH) ? model[raddr] : '0;
      if (wdata_vld && waddr < DEPTH) model[waddr] = wdata;
      else if (ld_vld && !wdata_vld && ld_addr < DEPTH) model[ld_addr] = ld_data;
      if (reset) begin
         exp_rd_cnt = '0;
         exp_wr_cnt = '0;
      end else begin
         if (raddr_vld) exp_rd_cnt = exp_rd_cnt + AW'(1);
         if (wdata_vld) exp_wr_cnt = exp_wr_cnt + AW'(1);
      end
      #1;
      if (do_rd) sb.push_back('{d: e, t: edge_cnt});
      @(negedge clk);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_addr = a; ld_data = d; ld_vld = 1'b1;
      tick();
      ld_vld = 1'b0;
   endtask

   task automatic read1(input logic [AW-1:0] a);
      raddr = a; raddr_vld = 1'b1;
      tick();
      raddr_vld = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4 * int'(MEM_DELAY) && sb.size() > 0; i++) @(negedge clk);
      chk(tag, DW'(sb.size()), DW'(0));
   endtask

   // Response monitor: every rdata_vld must match the queue head, at exact latency.
   always @(negedge clk) begin
      if (rdata_vld) begin
         if (sb.size() == 0) begin
            chk("spurious_rdata_vld", DW'(rdata_vld), DW'(0));
         end else begin
            resp_t r;
            r = sb.pop_front();
            chk("rdata", rdata, r.d);
            chk("latency", DW'(edge_cnt), DW'(r.t + int'(MEM_DELAY) - 1));
         end
      end else if (sb.size() > 0 && edge_cnt > sb[0].t + int'(MEM_DELAY) - 1) begin
         chk("missing_rdata_vld", DW'(rdata_vld), DW'(1));
         void'(sb.pop_front());
      end
   end

   initial begin
      reset = 1'b1; raddr = '0; raddr_vld = 1'b0; waddr = '0; wdata = '0; wdata_vld = 1'b0;
      ld_addr = '0; ld_data = '0; ld_vld = 1'b0; err_clr = 1'b0;
      pat_a5 = {64{8'hA5}};
      pat_p  = {16{32'h5A5A_0976}};
      repeat (3) @(negedge clk);
      chk("rst_rdata", rdata, '0);
      chk("rst_rdata_vld", DW'(rdata_vld), DW'(0));
      chk("rst_rd_cnt", DW'(rd_cnt), DW'(0));
      chk("rst_wr_cnt", DW'(wr_cnt), DW'(0));
      chk("rst_inflight", DW'(inflight), DW'(0));
      chk("rst_errs", DW'({rd_err, wr_err}), DW'(0));
      reset = 1'b0;
      repeat (2) tick();

      // Single read: one-cycle response, inflight held for MEM_DELAY cycles.
      preload(AW'(5), pat_a5);
      read1(AW'(5));
      for (int i = 0; i < int'(MEM_DELAY); i++) begin
         chk("t1_inflight", DW'(inflight), DW'(1));
         chk("t1_rdata_vld", DW'(rdata_vld), DW'(i == int'(MEM_DELAY) - 1));
         tick();
      end
      chk("t1_inflight_idle", DW'(inflight), DW'(0));
      chk("t1_rdata_hold", rdata, pat_a5);

      // Back-to-back reads of 16 preloaded words.
      for (int i = 0; i < 16; i++) preload(AW'(i), {16{32'hC0DE_0000 + 32'(i)}});
      raddr_vld = 1'b1;
      for (int i = 0; i < 16; i++) begin
         raddr = AW'(i);
         tick();
         if (i >= int'(MEM_DELAY) - 1) chk("t2_inflight_sat", DW'(inflight), DW'(MEM_DELAY));
      end
      raddr_vld = 1'b0;
      chk("t2_rd_cnt", DW'(rd_cnt), DW'(exp_rd_cnt));
      drain("t2_drain");
      chk("t2_inflight_idle", DW'(inflight), DW'(0));

      // Read-before-write on the same edge, then write visible one cycle later.
      preload(AW'(7), '0);
      waddr = AW'(7); wdata = DW'(1); wdata_vld = 1'b1;
      raddr = AW'(7); raddr_vld = 1'b1;
      tick();
      wdata_vld = 1'b0;
      tick();
      raddr_vld = 1'b0;
      drain("t3_drain");

      // Out-of-range accesses and error flag handling.
      preload(AW'(976), pat_p);
      read1(AW'(DEPTH));
      chk("t4_rd_err_set", DW'(rd_err), DW'(1));
      chk("t4_wr_err_clean", DW'(wr_err), DW'(0));
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t4_rd_err_clr", DW'(rd_err), DW'(0));
      err_clr = 1'b1; read1(AW'(DEPTH + 7)); err_clr = 1'b0;
      chk("t4_rd_err_clr_vs_set", DW'(rd_err), DW'(1));
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t4_rd_err_clr2", DW'(rd_err), DW'(0));
      waddr = AW'(2000); wdata = '1; wdata_vld = 1'b1;
      tick();
      wdata_vld = 1'b0;
      chk("t4_wr_err_set", DW'(wr_err), DW'(1));
      chk("t4_wr_cnt", DW'(wr_cnt), DW'(exp_wr_cnt));
      read1(AW'(976));
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t4_wr_err_clr", DW'(wr_err), DW'(0));
      preload(AW'(1500), '1);
      chk("t4_ld_err_set", DW'(wr_err), DW'(1));
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      drain("t4_drain");

      // Reset with reads in flight: they are dropped, array contents survive.
      raddr_vld = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         raddr = AW'(i);
         tick();
      end
      raddr_vld = 1'b0;
      chk("t5_inflight_pre", DW'(inflight), DW'(3));
      reset = 1'b1;
      sb.delete();
      exp_rd_cnt = '0;
      exp_wr_cnt = '0;
      #1;
      chk("t5_rst_inflight", DW'(inflight), DW'(0));
      chk("t5_rst_cnts", DW'({rd_cnt, wr_cnt}), DW'(0));
      chk("t5_rst_rdata", rdata, '0);
      repeat (2) tick();
      reset = 1'b0;
      for (int i = 0; i < int'(MEM_DELAY) + 4; i++) begin
         chk("t5_no_resp", DW'(rdata_vld), DW'(0));
         tick();
      end
      read1(AW'(7));
      read1(AW'(976));
      drain("t5_drain");

      // Write port beats preload at the same address; rd_cnt wraps.
      waddr = AW'(9); wdata = {16{32'hBEEF_0009}}; wdata_vld = 1'b1;
      ld_addr = AW'(9); ld_data = {16{32'hDEAD_0009}}; ld_vld = 1'b1;
      tick();
      wdata_vld = 1'b0; ld_vld = 1'b0;
      chk("t6_wr_err_clean", DW'(wr_err), DW'(0));
      read1(AW'(9));
      drain("t6_drain");
      raddr = AW'(9); raddr_vld = 1'b1;
      while (exp_rd_cnt != '1) tick();
      raddr_vld = 1'b0;
      chk("t6_rd_cnt_max", DW'(rd_cnt), DW'(16'hFFFF));
      read1(AW'(9));
      chk("t6_rd_cnt_wrap", DW'(rd_cnt), DW'(0));
      drain("t6_drain_wrap");
      chk("t6_inflight_idle", DW'(inflight), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
